aes_round_iter: RTL and testbench

- Iterative AES encryption engine built around one registered round datapath, reused for all rounds of a block.
- Successor to the single-round block. Parametrised for AES-128/192/256.
- Adds the initial AddRoundKey, the final round without MixColumns, and valid/ready handshakes on input and output.
- Sits between the key-expansion unit, which supplies the full expanded key bus, and the block-cipher mode/stream logic.

---
 rtl/aes_pkg.sv | 44 ++++
 rtl/aes_round_iter_if.sv | 22 ++
 rtl/aes_round_comb.sv | 49 ++++
 rtl/aes_round_iter.sv | 120 ++++++++++++
 tb/tb_aes_round_iter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table and lookup, GF(2^8) doubling,
// round count per key size, and the engine FSM state encoding.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_state_t;

   // Forward S-box, entry 0 in the most significant byte of the first row.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic int nr_of(input int key_bits);
      return key_bits / 32 + 6;
   endfunction

endpackage

// File: rtl/aes_round_iter_if.sv
// Block-level handshake bundle for aes_round_iter.
// Both channels are valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the producer holds valid and data stable
// until that edge, and the consumer may raise ready independently of valid.
interface aes_round_iter_if;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/aes_round_comb.sv
// One AES encryption round, purely combinational:
// SubBytes -> ShiftRows -> MixColumns (skipped on the final round) -> AddRoundKey.
// Byte i of the state lives at bits [127-8i -: 8]; byte 4c+r is row r, column c.
module aes_round_comb
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] rk,
   input  logic         final_rnd,
   output logic [127:0] nxt
);

   logic [127:0] sb;
   logic [127:0] sr;
   logic [127:0] mc;
   logic [7:0]   a0, a1, a2, a3;

   // Full round datapath: 16 parallel S-boxes, byte rotation, column mixing, key add.
   always_comb begin
      sb = '0;
      sr = '0;
      mc = '0;
      a0 = '0;
      a1 = '0;
      a2 = '0;
      a3 = '0;
      for (int i = 0; i < 16; i++) begin
         sb[127-8*i -: 8] = sbox(state[127-8*i -: 8]);
      end
      // Row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         a0 = sr[127-8*(4*c+0) -: 8];
         a1 = sr[127-8*(4*c+1) -: 8];
         a2 = sr[127-8*(4*c+2) -: 8];
         a3 = sr[127-8*(4*c+3) -: 8];
         mc[127-8*(4*c+0) -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         mc[127-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         mc[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         mc[127-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      nxt = (final_rnd ? sr : mc) ^ rk;
   end

endmodule

// File: rtl/aes_round_iter.sv
// Iterative AES encryption engine (AES-128/192/256 via KEY_BITS).
// One registered round per cycle; result appears NR edges after acceptance
// and is held until the consumer takes it.
// Optional build macro AES_KEY_LATCH_EN: capture the expanded key on the
// accepting edge so the key bus may change while a block is in flight.
module aes_round_iter
   import aes_pkg::*;
#(
   parameter  int KEY_BITS = 128,
   localparam int NR       = nr_of(KEY_BITS),
   localparam int RK_BITS  = 128 * (NR + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [RK_BITS-1:0] key,
   aes_round_iter_if.slave    bus,
   output logic               busy,
   output logic [3:0]         round_idx,
   output fsm_state_t         state_dbg
);

   if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
      $error("aes_round_iter: KEY_BITS must be 128, 192 or 256");
   end

   fsm_state_t         state;
   logic [127:0]       st;
   logic [127:0]       rnd_out;
   logic [127:0]       rk_cur;
   logic               final_rnd;
   logic               accept;
   logic [RK_BITS-1:0] rk_src;

   assign accept    = (state == IDLE) && bus.in_valid && bus.in_ready;
   assign state_dbg = state;

`ifdef AES_KEY_LATCH_EN
   logic [RK_BITS-1:0] key_q;

   // Snapshot the whole key schedule when a block is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         key_q <= '0;
      end else if (accept) begin
         key_q <= key;
      end
   end

   assign rk_src = key_q;
`else
   assign rk_src = key;
`endif

   // Select the round key for the round currently being computed.
   always_comb begin
      rk_cur    = rk_src[RK_BITS-1-128*int'(round_idx) -: 128];
      final_rnd = (round_idx == 4'(NR));
   end

   aes_round_comb u_round (
      .state     (st),
      .rk        (rk_cur),
      .final_rnd (final_rnd),
      .nxt       (rnd_out)
   );

   // Control FSM with registered handshake, status and result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         st            <= '0;
         round_idx     <= '0;
         busy          <= 1'b0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  // Initial AddRoundKey with rk0 happens on the accepting edge.
                  st           <= bus.in_data ^ key[RK_BITS-1 -: 128];
                  round_idx    <= 4'd1;
                  busy         <= 1'b1;
                  bus.in_ready <= 1'b0;
                  state        <= RUN;
               end
            end
            RUN: begin
               if (final_rnd) begin
                  bus.out_data  <= rnd_out;
                  bus.out_valid <= 1'b1;
                  round_idx     <= '0;
                  state         <= DONE;
               end else begin
                  st        <= rnd_out;
                  round_idx <= round_idx + 4'd1;
               end
            end
            DONE: begin
               // No turnaround in the same cycle: in_ready only returns in IDLE.
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  bus.in_ready  <= 1'b1;
                  busy          <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: begin
               state         <= IDLE;
               round_idx     <= '0;
               busy          <= 1'b0;
               bus.in_ready  <= 1'b1;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_round_iter.sv
// Bench for aes_round_iter: three instances (AES-128/192/256) sharing one
// stimulus stream, selected by 'sel'. Expected ciphertexts come from FIPS-197
// vectors and from a byte-matrix AES model whose S-box is derived from the
// GF(2^8) inverse plus affine map.
module tb_aes_round_iter;
   import aes_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int sel    = 0;

   logic          in_valid;
   logic          out_ready;
   logic [127:0]  in_data;
   logic [1407:0] key128;
   logic [1663:0] key192;
   logic [1919:0] key256;

   aes_round_iter_if b0 ();
   aes_round_iter_if b1 ();
   aes_round_iter_if b2 ();

   assign b0.in_valid  = in_valid && (sel == 0);
   assign b1.in_valid  = in_valid && (sel == 1);
   assign b2.in_valid  = in_valid && (sel == 2);
   assign b0.in_data   = in_data;
   assign b1.in_data   = in_data;
   assign b2.in_data   = in_data;
   assign b0.out_ready = out_ready && (sel == 0);
   assign b1.out_ready = out_ready && (sel == 1);
   assign b2.out_ready = out_ready && (sel == 2);

   logic       busy0, busy1, busy2;
   logic [3:0] rid0, rid1, rid2;
   fsm_state_t dbg0, dbg1, dbg2;

   aes_round_iter #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .key(key128), .bus(b0),
      .busy(busy0), .round_idx(rid0), .state_dbg(dbg0));
   aes_round_iter #(.KEY_BITS(192)) u192 (.clk(clk), .rst(rst), .key(key192), .bus(b1),
      .busy(busy1), .round_idx(rid1), .state_dbg(dbg1));
   aes_round_iter #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .key(key256), .bus(b2),
      .busy(busy2), .round_idx(rid2), .state_dbg(dbg2));

   logic         o_in_ready, o_out_valid, o_busy;
   logic [3:0]   o_rid;
   logic [127:0] o_out_data;

   always_comb begin
      o_in_ready  = b0.in_ready;
      o_out_valid = b0.out_valid;
      o_out_data  = b0.out_data;
      o_busy      = busy0;
      o_rid       = rid0;
      case (sel)
         1: begin
            o_in_ready = b1.in_ready; o_out_valid = b1.out_valid; o_out_data = b1.out_data;
            o_busy = busy1; o_rid = rid1;
         end
         2: begin
            o_in_ready = b2.in_ready; o_out_valid = b2.out_valid; o_out_data = b2.out_data;
            o_busy = busy2; o_rid = rid2;
         end
         default: ;
      endcase
   end

   // ---------------- reference model ----------------
   logic [7:0]   sbox_t [256];
   logic [31:0]  w      [60];
   logic [127:0] m_rk   [15];

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
      logic [15:0] d;
      d = {b, b} << n;
      return d[15:8];
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         sbox_t[x] = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
   endfunction

   // Key schedule from an MSB-aligned cipher key of nk words; loads the DUT key bus.
   task automatic expand(input logic [255:0] ck, input int nk);
      logic [31:0] t;
      logic [7:0]  rc;
      int          nr;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[i] = ck[255-32*i -: 32];
         end else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t = subw({t[23:0], t[31:24]});
               t[31:24] = t[31:24] ^ rc;
               rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
               t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
         end
      end
      for (int r = 0; r <= nr; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      case (nk)
         4: for (int r = 0; r <= 10; r++) key128[1407-128*r -: 128] = m_rk[r];
         6: for (int r = 0; r <= 12; r++) key192[1663-128*r -: 128] = m_rk[r];
         default: for (int r = 0; r <= 14; r++) key256[1919-128*r -: 128] = m_rk[r];
      endcase
   endtask

   function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            s[r][c] = pt[127-8*(4*c+r) -: 8] ^ m_rk[0][127-8*(4*c+r) -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r][c] = sbox_t[s[(r)][(c+r)%4]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
               if (rnd < nr)
                  s[r][c] = gm(8'h02, t[r][c]) ^ gm(8'h03, t[(r+1)%4][c]) ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
               else
                  s[r][c] = t[r][c];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r][c] = s[r][c] ^ m_rk[rnd][127-8*(4*c+r) -: 8];
      end
      res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) res[127-8*(4*c+r) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- scoreboard ----------------
   logic [127:0] exp_q[$];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int cur_nr();
      return 10 + 2 * sel;
   endfunction

   // ---------------- driver tasks ----------------
   // Leaves the bench at the negedge right after the accepting edge.
   task automatic start_block(input string tag, input logic [127:0] pt, input logic [127:0] exp);
      int k;
      k = 0;
      while (o_in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk({tag, "_in_ready_idle"}, 128'(o_in_ready), 128'h1);
      in_data  = pt;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk({tag, "_busy_run"}, 128'(o_busy), 128'h1);
      chk({tag, "_in_ready_run"}, 128'(o_in_ready), 128'h0);
      chk({tag, "_round_idx_first"}, 128'(o_rid), 128'h1);
      exp_q.push_back(exp);
   endtask

   task automatic finish_block(input string tag, input int lat0, input int stall);
      int           lat;
      logic [127:0] exp;
      lat = lat0;
      while (o_out_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_latency"}, 128'(lat), 128'(cur_nr()));
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      chk({tag, "_out_data"}, o_out_data, exp);
      chk({tag, "_round_idx_done"}, 128'(o_rid), 128'h0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({tag, "_stall_data"}, o_out_data, exp);
         chk({tag, "_stall_valid"}, 128'(o_out_valid), 128'h1);
         chk({tag, "_stall_in_ready"}, 128'(o_in_ready), 128'h0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 128'(o_out_valid), 128'h0);
      chk({tag, "_in_ready_back"}, 128'(o_in_ready), 128'h1);
      chk({tag, "_busy_clear"}, 128'(o_busy), 128'h0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      logic [255:0] ck;
      logic [127:0] pt;
      int           k;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      key128    = '0;
      key192    = '0;
      key256    = '0;
      build_sbox();

      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 3; s++) begin
         sel = s;
         #1;
         chk("reset_in_ready", 128'(o_in_ready), 128'h1);
         chk("reset_out_valid", 128'(o_out_valid), 128'h0);
         chk("reset_out_data", o_out_data, 128'h0);
         chk("reset_busy", 128'(o_busy), 128'h0);
         chk("reset_round_idx", 128'(o_rid), 128'h0);
      end
      @(negedge clk);
      rst = 1'b0;
      sel = 0;
      @(negedge clk);

      // FIPS-197 App. B
      expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
      start_block("fips_b", 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
      finish_block("fips_b", 0, 0);

      // FIPS-197 C.1 with a stray in_valid pulse during RUN
      expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
      start_block("c1_pulse", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      repeat (3) @(negedge clk);
      in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("c1_pulse_in_ready", 128'(o_in_ready), 128'h0);
      chk("c1_pulse_round_idx", 128'(o_rid), 128'h5);
      finish_block("c1_pulse", 4, 0);

      // Back-pressure: 20 cycles with out_ready low
      start_block("bp", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      finish_block("bp", 0, 20);

      // FIPS-197 C.2 / C.3
      sel = 1;
      expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6);
      start_block("fips_c2", 128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191);
      finish_block("fips_c2", 0, 0);
      sel = 2;
      expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);
      start_block("fips_c3", 128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089);
      finish_block("fips_c3", 0, 0);

      // Reset at round 5, then a clean block
      sel = 0;
      start_block("rst_mid", {$urandom(), $urandom(), $urandom(), $urandom()}, '0);
      k = 0;
      while (o_rid !== 4'd5 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rst_mid_round5", 128'(o_rid), 128'h5);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
      chk("rst_mid_busy", 128'(o_busy), 128'h0);
      chk("rst_mid_in_ready", 128'(o_in_ready), 128'h1);
      chk("rst_mid_out_valid", 128'(o_out_valid), 128'h0);
      chk("rst_mid_round_idx", 128'(o_rid), 128'h0);
      chk("rst_mid_out_data", o_out_data, 128'h0);
      start_block("after_rst", 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      finish_block("after_rst", 0, 0);

`ifdef AES_KEY_LATCH_EN
      // Key bus scrambled one cycle after acceptance
      expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4);
      start_block("key_latch", 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
      @(negedge clk);
      key128 = '1;
      finish_block("key_latch", 1, 0);
`endif

      // Random keys and plaintexts against the model
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int n = 0; n < 4; n++) begin
            ck = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
            expand(ck, 4 + 2 * s);
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            start_block("rand", pt, model_enc(pt, cur_nr()));
            finish_block("rand", 0, $urandom_range(0, 3));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
